// File: rtl/data_mem_controller_if.sv
// Data SRAM bus between the MEM-stage controller and the data memory.
// The controller issues a request with address/write fields, the memory
// answers with addr_ok (request accepted) and data_ok (data phase done).
interface data_mem_controller_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_addr,
           data_sram_wstrb, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/data_mem_controller.sv
// MEM-stage data memory controller: turns one load/store from the pipeline
// into a single request/response transaction on the data SRAM bus, stalls
// the pipeline while it is outstanding and latches the raw read word.
module data_mem_controller (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [1:0]  mem_width,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        flush,
  output logic        mem_stall,
  output logic        mem_done,
  output logic [31:0] mem_rdata,
  output logic        addr_err,
  data_mem_controller_if.master bus
);

  // Access width codes; they double as the bus size encoding.
  localparam logic [1:0] MEM_WIDTH1 = 2'd0;
  localparam logic [1:0] MEM_WIDTH2 = 2'd1;
  localparam logic [1:0] MEM_WIDTH4 = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        cancel_q, cancel_d;
  logic        write_q, write_d;
  logic [1:0]  width_q, width_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        resp_taken;
  logic        cancel_now;

  // Misalignment detect on the incoming access; such accesses never reach the bus.
  always_comb begin
    addr_err = mem_valid &
               (((mem_width == MEM_WIDTH2) & mem_addr[0]) |
                ((mem_width == MEM_WIDTH4) & (mem_addr[1:0] != 2'b00)));
  end

  // Pipeline hold: a live access stalls until its response cycle; flush and reset release it.
  always_comb begin
    mem_stall = resetn & mem_valid & ~addr_err & ~flush & (state_q != S_RESP);
  end

  // Next-state, transaction latch, cancel tracking and read-data capture.
  always_comb begin
    state_d    = state_q;
    cancel_d   = cancel_q;
    write_d    = write_q;
    width_d    = width_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    mem_done   = 1'b0;
    resp_taken = 1'b0;
    cancel_now = cancel_q | flush;
    case (state_q)
      S_IDLE: begin
        cancel_d = 1'b0;
        if (mem_valid & ~addr_err & ~flush) begin
          write_d = mem_write;
          width_d = mem_width;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_sram_addr_ok) begin
          if (bus.data_sram_data_ok) resp_taken = 1'b1;
          else state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) cancel_d = 1'b1;
        if (bus.data_sram_data_ok) resp_taken = 1'b1;
      end
      S_RESP: begin
        mem_done = ~flush;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (resp_taken) begin
      if (~write_q & ~cancel_now) rdata_d = bus.data_sram_rdata;
      state_d  = cancel_now ? S_IDLE : S_RESP;
      cancel_d = 1'b0;
    end
  end

  // Bus fields come from the latched access so they stay stable until addr_ok.
  always_comb begin
    bus.data_sram_req   = (state_q == S_REQ);
    bus.data_sram_wr    = write_q;
    bus.data_sram_size  = width_q;
    bus.data_sram_addr  = addr_q;
    bus.data_sram_wstrb = 4'b0000;
    bus.data_sram_wdata = wdata_q;
    case (width_q)
      MEM_WIDTH1: bus.data_sram_wdata = {4{wdata_q[7:0]}};
      MEM_WIDTH2: bus.data_sram_wdata = {2{wdata_q[15:0]}};
      default:    bus.data_sram_wdata = wdata_q;
    endcase
    if ((state_q == S_REQ) & write_q) begin
      case (width_q)
        MEM_WIDTH1: bus.data_sram_wstrb = 4'b0001 << addr_q[1:0];
        MEM_WIDTH2: bus.data_sram_wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
        MEM_WIDTH4: bus.data_sram_wstrb = 4'b1111;
        default:    bus.data_sram_wstrb = 4'b0000;
      endcase
    end
  end

  // State and latched transaction registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cancel_q <= 1'b0;
      write_q  <= 1'b0;
      width_q  <= 2'b00;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cancel_q <= cancel_d;
      write_q  <= write_d;
      width_q  <= width_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  assign mem_rdata = rdata_q;

endmodule
